// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the MIPS data memory and its MMIO peripherals.
// Holds the data width, the MMIO register addresses and the TMR_CTRL bit layout.
package mips_pkg;

    localparam int MIPS_Size = 32;

    localparam logic [31:0] GPIO_OUT_ADDR  = 32'hFFFF_0000;
    localparam logic [31:0] GPIO_IN_ADDR   = 32'hFFFF_0004;
    localparam logic [31:0] TMR_COUNT_ADDR = 32'hFFFF_0008;
    localparam logic [31:0] TMR_CMP_ADDR   = 32'hFFFF_000C;
    localparam logic [31:0] TMR_CTRL_ADDR  = 32'hFFFF_0010;

    localparam int TMR_CTRL_EN     = 0;
    localparam int TMR_CTRL_RELOAD = 1;
    localparam int TMR_CTRL_MATCH  = 2;
    localparam int TMR_CTRL_IRQ_EN = 3;

    // Which timer register a store is aimed at.
    typedef enum logic [1:0] {
        TMR_SEL_COUNT = 2'd0,
        TMR_SEL_CMP   = 2'd1,
        TMR_SEL_CTRL  = 2'd2,
        TMR_SEL_NONE  = 2'd3
    } tmr_sel_e;

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: free-running 32-bit counter with compare, auto-reload and a
// sticky MATCH flag that drives a level interrupt.
module mmio_timer
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  tmr_sel_e    wr_sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] cmp_o,
    output logic [31:0] ctrl_o,
    output logic        irq_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q, cmp_d;
    logic        en_q, en_d;
    logic        reload_q, reload_d;
    logic        match_q, match_d;
    logic        irq_en_q, irq_en_d;
    logic        hit;

    assign hit = en_q && (count_q == cmp_q);

    // Next-state: counting first, then software writes override, and a compare hit
    // overrides a software clear of MATCH.
    always_comb begin
        count_d  = count_q;
        cmp_d    = cmp_q;
        en_d     = en_q;
        reload_d = reload_q;
        match_d  = match_q;
        irq_en_d = irq_en_q;
        if (en_q) begin
            count_d = (hit && reload_q) ? 32'd0 : count_q + 32'd1;
        end
        if (wr_en_i) begin
            case (wr_sel_i)
                TMR_SEL_COUNT: count_d = wdata_i;
                TMR_SEL_CMP:   cmp_d   = wdata_i;
                TMR_SEL_CTRL: begin
                    en_d     = wdata_i[TMR_CTRL_EN];
                    reload_d = wdata_i[TMR_CTRL_RELOAD];
                    irq_en_d = wdata_i[TMR_CTRL_IRQ_EN];
                    if (wdata_i[TMR_CTRL_MATCH]) begin
                        match_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (hit) begin
            match_d = 1'b1;
        end
    end

    // Timer state registers, cleared by reset so a running count leaves no MATCH behind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            cmp_q    <= '0;
            en_q     <= 1'b0;
            reload_q <= 1'b0;
            match_q  <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            en_q     <= en_d;
            reload_q <= reload_d;
            match_q  <= match_d;
            irq_en_q <= irq_en_d;
        end
    end

    assign count_o = count_q;
    assign cmp_o   = cmp_q;
    assign ctrl_o  = {28'd0, irq_en_q, match_q, reload_q, en_q};
    assign irq_o   = match_q & irq_en_q;

endmodule

// File: rtl/data_memory_mmio.sv
// data_memory_mmio: word-addressed data RAM plus memory-mapped GPIO and an
// optional timer for a single-cycle MIPS datapath. Loads are combinational.
// Define DMEM_TIMER_EN to include the timer; otherwise its addresses read 0.
module data_memory_mmio #(
    parameter int MIPS_Size = mips_pkg::MIPS_Size,
    parameter int RAM_DEPTH = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [MIPS_Size-1:0] Addr,
    input  logic [MIPS_Size-1:0] WD,
    input  logic                 MemWrite,
    input  logic [15:0]          GPIO_in,
    output logic [MIPS_Size-1:0] ReadData,
    output logic [15:0]          GPIO_out,
    output logic                 Timer_irq
);
    import mips_pkg::*;

    localparam int AW = $clog2(RAM_DEPTH);

    logic [31:0]          addr_w;
    logic [29:0]          word_addr;
    logic [1:0]           unused_byte_sel;
    logic                 ram_hit;
    logic [AW-1:0]        ram_idx;
    logic [MIPS_Size-1:0] ram_q [RAM_DEPTH];
    logic [15:0]          gpio_out_q;
    logic [15:0]          sync1_q;
    logic [15:0]          sync2_q;

    assign addr_w          = 32'(Addr);
    assign word_addr       = addr_w[31:2];
    assign unused_byte_sel = addr_w[1:0];
    assign ram_hit         = (word_addr[29:AW] == '0);
    assign ram_idx         = word_addr[AW-1:0];

    // RAM array: cleared as a whole on reset, written on a store into the RAM window.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                ram_q[i] <= '0;
            end
        end else if (MemWrite && ram_hit) begin
            ram_q[ram_idx] <= WD;
        end
    end

    // GPIO output register and two-flop synchroniser for the external inputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
        end else begin
            if (MemWrite && (word_addr == GPIO_OUT_ADDR[31:2])) begin
                gpio_out_q <= WD[15:0];
            end
            sync1_q <= GPIO_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef DMEM_TIMER_EN
    tmr_sel_e    tmr_sel;
    logic [31:0] tmr_count;
    logic [31:0] tmr_cmp;
    logic [31:0] tmr_ctrl;
    logic        tmr_irq;

    // Decode which timer register the current address selects.
    always_comb begin
        tmr_sel = TMR_SEL_NONE;
        if (word_addr == TMR_COUNT_ADDR[31:2]) begin
            tmr_sel = TMR_SEL_COUNT;
        end else if (word_addr == TMR_CMP_ADDR[31:2]) begin
            tmr_sel = TMR_SEL_CMP;
        end else if (word_addr == TMR_CTRL_ADDR[31:2]) begin
            tmr_sel = TMR_SEL_CTRL;
        end
    end

    mmio_timer u_timer (
        .clk_i    (CLK),
        .rst_ni   (RST),
        .wr_en_i  (MemWrite && (tmr_sel != TMR_SEL_NONE)),
        .wr_sel_i (tmr_sel),
        .wdata_i  (32'(WD)),
        .count_o  (tmr_count),
        .cmp_o    (tmr_cmp),
        .ctrl_o   (tmr_ctrl),
        .irq_o    (tmr_irq)
    );

    assign Timer_irq = tmr_irq;
`else
    assign Timer_irq = 1'b0;
`endif

    // Load path: RAM window first, then the MMIO registers; anything else reads 0.
    always_comb begin
        ReadData = '0;
        if (ram_hit) begin
            ReadData = ram_q[ram_idx];
        end else begin
            case (word_addr)
                GPIO_OUT_ADDR[31:2]:  ReadData = MIPS_Size'({16'd0, gpio_out_q});
                GPIO_IN_ADDR[31:2]:   ReadData = MIPS_Size'({16'd0, sync2_q});
`ifdef DMEM_TIMER_EN
                TMR_COUNT_ADDR[31:2]: ReadData = MIPS_Size'(tmr_count);
                TMR_CMP_ADDR[31:2]:   ReadData = MIPS_Size'(tmr_cmp);
                TMR_CTRL_ADDR[31:2]:  ReadData = MIPS_Size'(tmr_ctrl);
`endif
                default:              ReadData = '0;
            endcase
        end
    end

    assign GPIO_out = gpio_out_q;

endmodule

// File: tb/tb_data_memory_mmio.sv
// tb_data_memory_mmio: scoreboard bench for data_memory_mmio with directed and
// randomized loads/stores. The reference model follows DMEM_TIMER_EN like the design.
module tb_data_memory_mmio;

    localparam int          DEPTH  = 64;
    localparam logic [31:0] A_GPO  = 32'hFFFF_0000;
    localparam logic [31:0] A_GPI  = 32'hFFFF_0004;
    localparam logic [31:0] A_CNT  = 32'hFFFF_0008;
    localparam logic [31:0] A_CMP  = 32'hFFFF_000C;
    localparam logic [31:0] A_CTRL = 32'hFFFF_0010;
    localparam int          K_RD   = 0;
    localparam int          K_GPO  = 1;
    localparam int          K_IRQ  = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        MemWrite;
    logic [15:0] GPIO_in;
    logic [31:0] ReadData;
    logic [15:0] GPIO_out;
    logic        Timer_irq;

    data_memory_mmio #(.MIPS_Size(32), .RAM_DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Addr      (Addr),
        .WD        (WD),
        .MemWrite  (MemWrite),
        .GPIO_in   (GPIO_in),
        .ReadData  (ReadData),
        .GPIO_out  (GPIO_out),
        .Timer_irq (Timer_irq)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] expv;
        logic [31:0] addr;
    } exp_t;

    exp_t expQ[$];
    int   cycleCount  = 0;
    int   vectors     = 0;
    int   miscompares = 0;

    // Cycle index used to pair each expectation with the cycle it was issued in.
    always @(posedge CLK) cycleCount <= cycleCount + 1;

    // Reference model state, kept as plain architectural registers.
    logic [31:0] mMem [DEPTH];
    logic [15:0] mGpo;
    logic [15:0] mSync1;
    logic [15:0] mSync2;
    logic [31:0] mCount;
    logic [31:0] mCmp;
    logic        mEn;
    logic        mReload;
    logic        mMatch;
    logic        mIrqEn;

    function automatic void resetModel();
        for (int i = 0; i < DEPTH; i++) mMem[i] = 32'h0;
        mGpo    = 16'h0;
        mSync1  = 16'h0;
        mSync2  = 16'h0;
        mCount  = 32'h0;
        mCmp    = 32'h0;
        mEn     = 1'b0;
        mReload = 1'b0;
        mMatch  = 1'b0;
        mIrqEn  = 1'b0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        if (w < DEPTH * 4) return mMem[int'(w >> 2)];
        case (w)
            A_GPO:  return {16'h0, mGpo};
            A_GPI:  return {16'h0, mSync2};
`ifdef DMEM_TIMER_EN
            A_CNT:  return mCount;
            A_CMP:  return mCmp;
            A_CTRL: return {28'h0, mIrqEn, mMatch, mReload, mEn};
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic modelIrq();
`ifdef DMEM_TIMER_EN
        return mMatch & mIrqEn;
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model across one rising edge with the given bus inputs.
    function automatic void stepModel(input logic [31:0] a, input logic [31:0] wd,
                                      input logic we, input logic [15:0] gin);
        logic [31:0] w;
`ifdef DMEM_TIMER_EN
        logic        hit;
        logic [31:0] nCount;
        logic        nMatch;
`endif
        w = a & 32'hFFFF_FFFC;
`ifdef DMEM_TIMER_EN
        hit    = mEn && (mCount == mCmp);
        nCount = mCount;
        nMatch = mMatch;
        if (mEn) nCount = (hit && mReload) ? 32'h0 : mCount + 32'h1;
        if (we && w == A_CNT) nCount = wd;
        if (we && w == A_CMP) mCmp = wd;
        if (we && w == A_CTRL) begin
            mEn     = wd[0];
            mReload = wd[1];
            mIrqEn  = wd[3];
            if (wd[2]) nMatch = 1'b0;
        end
        if (hit) nMatch = 1'b1;
        mCount = nCount;
        mMatch = nMatch;
`endif
        if (we && w < DEPTH * 4) mMem[int'(w >> 2)] = wd;
        if (we && w == A_GPO) mGpo = wd[15:0];
        mSync2 = mSync1;
        mSync1 = gin;
    endfunction

    // Drive one bus cycle (called just after a rising edge), queue its expected
    // outputs, update the model and move to just after the next rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd,
                                 input logic we, input logic [15:0] gin);
        Addr     = a;
        WD       = wd;
        MemWrite = we;
        GPIO_in  = gin;
        expQ.push_back('{cycleCount, K_RD, modelRead(a), a});
        expQ.push_back('{cycleCount, K_GPO, {16'h0, mGpo}, a});
        expQ.push_back('{cycleCount, K_IRQ, {31'h0, modelIrq()}, a});
        if (RST) stepModel(a, wd, we, gin);
        @(posedge CLK);
        #1;
    endtask

    function automatic string kindName(input int k);
        case (k)
            K_RD:    return "ReadData";
            K_GPO:   return "GPIO_out";
            default: return "Timer_irq";
        endcase
    endfunction

    // Monitor: on each falling edge compare every expectation issued for this cycle.
    task automatic checkOutput();
        exp_t        e;
        logic [31:0] act;
        while (expQ.size() > 0 && expQ[0].cyc <= cycleCount) begin
            e = expQ.pop_front();
            case (e.kind)
                K_RD:    act = ReadData;
                K_GPO:   act = {16'h0, GPIO_out};
                default: act = {31'h0, Timer_irq};
            endcase
            vectors++;
            if (e.cyc != cycleCount || act !== e.expv) begin
                miscompares++;
                $display("[TB] FAIL %s addr=0x%08h cyc=%0d actual=0x%08h expected=0x%08h",
                         kindName(e.kind), e.addr, e.cyc, act, e.expv);
            end
        end
    endtask

    always @(negedge CLK) checkOutput();

    // Stimulus: reset, directed scenarios, randomized traffic, reset mid-run.
    initial begin
        logic [31:0] ra;
        RST      = 1'b0;
        Addr     = 32'h0;
        WD       = 32'h0;
        MemWrite = 1'b0;
        GPIO_in  = 16'h0;
        resetModel();
        @(posedge CLK);
        #1;

        // Reset state: stores are ignored and everything reads zero.
        applyStimulus(32'h10, 32'h5555_5555, 1'b1, 16'hFFFF);
        applyStimulus(32'h10, 32'h0, 1'b0, 16'hFFFF);
        applyStimulus(A_GPO, 32'h0, 1'b0, 16'h0);
        RST = 1'b1;

        // RAM store then loads with ignored byte offset and a neighbouring word.
        applyStimulus(32'h10, 32'hDEAD_BEEF, 1'b1, 16'h0);
        applyStimulus(32'h10, 32'h0, 1'b0, 16'h0);
        applyStimulus(32'h13, 32'h0, 1'b0, 16'h0);
        applyStimulus(32'h14, 32'h0, 1'b0, 16'h0);
        applyStimulus(32'h10, 32'h0BAD_F00D, 1'b1, 16'h0);
        applyStimulus(32'h10, 32'h0, 1'b0, 16'h0);

        // GPIO output register.
        applyStimulus(A_GPO, 32'h1234_ABCD, 1'b1, 16'h0);
        applyStimulus(A_GPO, 32'h0, 1'b0, 16'h0);
        applyStimulus(32'hFFFF_0002, 32'h0, 1'b0, 16'h0);

        // GPIO input through the synchroniser.
        for (int i = 0; i < 4; i++) applyStimulus(A_GPI, 32'h0, 1'b0, 16'h00F0);

        // RAM window edges, unmapped space and read-only GPIO_IN.
        applyStimulus(32'hFC, 32'hCAFE_F00D, 1'b1, 16'h00F0);
        applyStimulus(32'hFC, 32'h0, 1'b0, 16'h00F0);
        applyStimulus(32'h100, 32'h1111_1111, 1'b1, 16'h00F0);
        applyStimulus(32'h100, 32'h0, 1'b0, 16'h00F0);
        applyStimulus(32'h0, 32'h0, 1'b0, 16'h00F0);
        applyStimulus(A_GPI, 32'h0000_5A5A, 1'b1, 16'h00F0);
        applyStimulus(A_GPI, 32'h0, 1'b0, 16'h00F0);
        applyStimulus(32'hFFFF_0014, 32'h7777_7777, 1'b1, 16'h00F0);
        applyStimulus(32'hFFFF_0014, 32'h0, 1'b0, 16'h00F0);

        // Timer: compare 5 with auto-reload and interrupt enabled.
        applyStimulus(A_CMP, 32'd5, 1'b1, 16'h0);
        applyStimulus(A_CTRL, 32'hB, 1'b1, 16'h0);
        for (int i = 0; i < 14; i++) applyStimulus(A_CNT, 32'h0, 1'b0, 16'h0);
        applyStimulus(A_CTRL, 32'h0, 1'b0, 16'h0);
`ifdef DMEM_TIMER_EN
        // Software clear in the same cycle as a new match: the match wins.
        for (int i = 0; i < 10 && !(mEn && mCount == mCmp); i++)
            applyStimulus(A_CNT, 32'h0, 1'b0, 16'h0);
        applyStimulus(A_CTRL, 32'hF, 1'b1, 16'h0);
        applyStimulus(A_CTRL, 32'h0, 1'b0, 16'h0);
        for (int i = 0; i < 10 && mCount != 32'd2; i++)
            applyStimulus(A_CTRL, 32'h0, 1'b0, 16'h0);
        applyStimulus(A_CTRL, 32'hF, 1'b1, 16'h0);
        applyStimulus(A_CTRL, 32'h0, 1'b0, 16'h0);
        // Software count write beats the increment, then wraps through zero.
        applyStimulus(A_CNT, 32'hFFFF_FFFE, 1'b1, 16'h0);
        for (int i = 0; i < 4; i++) applyStimulus(A_CNT, 32'h0, 1'b0, 16'h0);
`endif

        // Randomized mix of RAM, MMIO and unmapped accesses.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ra = {22'h0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
                6:       ra = A_GPO | 32'($urandom_range(0, 3));
                7:       ra = A_GPI;
                8:       ra = A_CNT + 32'(4 * $urandom_range(0, 2));
                default: ra = $urandom;
            endcase
            applyStimulus(ra, $urandom, ($urandom_range(0, 2) == 0), 16'($urandom));
        end

        // Reset while the timer runs and after a RAM store.
        applyStimulus(A_CMP, 32'd3, 1'b1, 16'h0);
        applyStimulus(A_CTRL, 32'hB, 1'b1, 16'h0);
        applyStimulus(A_GPO, 32'h0000_BEEF, 1'b1, 16'h0);
        applyStimulus(32'h20, 32'h1234_5678, 1'b1, 16'h0);
        for (int i = 0; i < 5; i++) applyStimulus(A_CNT, 32'h0, 1'b0, 16'h0);
        RST = 1'b0;
        resetModel();
        applyStimulus(32'h20, 32'hFFFF_FFFF, 1'b1, 16'hFFFF);
        applyStimulus(A_CNT, 32'h0, 1'b0, 16'hFFFF);
        applyStimulus(A_CTRL, 32'h0, 1'b0, 16'hFFFF);
        applyStimulus(A_GPO, 32'h0, 1'b0, 16'hFFFF);
        RST = 1'b1;
        applyStimulus(32'h20, 32'h0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) applyStimulus(A_CTRL, 32'h0, 1'b0, 16'h0);

        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain actual=%0d entries left expected=0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_memory_mmio.md
DATA_MEMORY_MMIO -- requirements
Module: data_memory_mmio

Interface
REQ-001 Parameter: MIPS_Size, default 32, data/address width.
REQ-002 Parameter: RAM_DEPTH, default 64, number of RAM words (power of two).
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 Addr  input  MIPS_Size  byte address, driven by the datapath ALU result.
REQ-006 WD  input  MIPS_Size  store data, driven by register-file RD2.
REQ-007 MemWrite  input  1  write strobe from the control unit.
REQ-008 GPIO_in  input  16  asynchronous external inputs.
REQ-009 ReadData  output  MIPS_Size  load data, returned combinationally to the datapath result mux.
REQ-010 GPIO_out  output  16  registered output port.
REQ-011 Timer_irq  output  1  timer interrupt request, level, active-high.

Function
REQ-012 Address map SHALL be: 0x0000_0000..(RAM_DEPTH*4-4) RAM; 0xFFFF_0000 GPIO_OUT (RW); 0xFFFF_0004 GPIO_IN (RO); 0xFFFF_0008 TMR_COUNT (RW); 0xFFFF_000C TMR_CMP (RW); 0xFFFF_0010 TMR_CTRL (RW).
REQ-013 Addr[1:0] SHALL be ignored; every access is a word access.
REQ-014 Reads SHALL be combinational (zero-cycle latency), so a single-cycle datapath completes the load in the same cycle.
REQ-015 Writes SHALL take effect at the rising edge where MemWrite=1; a read of the same address in that cycle returns the old value.
REQ-016 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored; writes to GPIO_IN SHALL be ignored.
REQ-017 GPIO_out SHALL equal GPIO_OUT[15:0]; upper 16 bits read as 0.
REQ-018 GPIO_in SHALL pass through a two-flop synchroniser; GPIO_IN reads the synchronised value zero-extended, 2-cycle latency.
REQ-019 TMR_CTRL bits: [0] EN, [1] AUTO_RELOAD, [2] MATCH (sticky), [3] IRQ_EN; bits [31:4] read 0.
REQ-020 With EN=1, TMR_COUNT SHALL increment by 1 per cycle, wrapping 0xFFFF_FFFF -> 0.
REQ-021 When EN=1 and TMR_COUNT==TMR_CMP, MATCH SHALL set on the next edge; with AUTO_RELOAD=1, TMR_COUNT SHALL load 0 on that edge instead of incrementing.
REQ-022 A write to TMR_CTRL with bit2=1 SHALL clear MATCH; writing bit2=0 SHALL leave MATCH unchanged.
REQ-023 If a MATCH set and a software clear occur in the same cycle, set SHALL win.
REQ-024 If a software write to TMR_COUNT coincides with an increment or reload, the software value SHALL win.
REQ-025 Timer_irq SHALL equal MATCH & IRQ_EN, registered-source, no extra latency.

Reset
REQ-026 On RST low, all RAM words, GPIO_OUT, synchroniser flops, TMR_COUNT, TMR_CMP and TMR_CTRL SHALL clear to 0 immediately.
REQ-027 During reset, GPIO_out=0, Timer_irq=0, and ReadData reflects the zeroed state.
REQ-028 Reset asserted mid-count SHALL abort the timer with no residual MATCH.

Configuration
REQ-029 Macro DMEM_TIMER_EN: when defined, the timer (REQ-019..025) SHALL be present.
REQ-030 Without DMEM_TIMER_EN, timer addresses SHALL behave as unmapped (read 0, writes ignored), and Timer_irq SHALL be tied to 0.

Structure
REQ-031 Shared package mips_pkg SHALL hold MIPS_Size, the MMIO address constants and the TMR_CTRL bit indices.
REQ-032 The timer SHALL be a sub-module mmio_timer, instantiated only under DMEM_TIMER_EN.

Verification
REQ-033 Store 0xDEADBEEF to 0x10, then load 0x10 and 0x13 -> both return 0xDEADBEEF; load 0x14 -> 0.
REQ-034 Write 0x1234_ABCD to 0xFFFF_0000 -> GPIO_out=0xABCD next cycle; readback=0x0000_ABCD.
REQ-035 Drive GPIO_in=0x00F0 -> GPIO_IN reads 0 until the second edge, then 0x0000_00F0.
REQ-036 TMR_CMP=5, TMR_CTRL=0xB -> MATCH and Timer_irq rise 6 cycles after EN; count returns to 0 and repeats each 6 cycles.
REQ-037 Write TMR_CTRL=0xF in the cycle MATCH sets -> MATCH stays 1; a later write of 0xF clears it.
REQ-038 Assert RST while the timer is running and after a RAM store -> all reads return 0; Timer_irq=0; GPIO_out=0.
